// File: rtl/caliptra_fpga_axil_initiator_if.sv
// Command/response and AXI4-Lite signal bundle for the FPGA AXI4-Lite initiator.
// The master modport is the initiator; the slave modport is the user plus AXI target.
interface caliptra_fpga_axil_initiator_if #(
    parameter int unsigned LAT_W = 16
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [31:0]      cmd_addr;
    logic [63:0]      cmd_wdata;
    logic [7:0]       cmd_wstrb;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_rdata;
    logic [1:0]       rsp_resp;
    logic             rsp_write;
    logic [LAT_W-1:0] rsp_cycles;
    logic             arvalid;
    logic [31:0]      araddr;
    logic [2:0]       arprot;
    logic             arready;
    logic             rvalid;
    logic [63:0]      rdata;
    logic [1:0]       rresp;
    logic             rready;
    logic             awvalid;
    logic [31:0]      awaddr;
    logic [2:0]       awprot;
    logic             awready;
    logic             wvalid;
    logic [63:0]      wdata;
    logic [7:0]       wstrb;
    logic             wready;
    logic             bvalid;
    logic [1:0]       bresp;
    logic             bready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_write, rsp_cycles,
        output arvalid, araddr, arprot, rready, awvalid, awaddr, awprot,
        output wvalid, wdata, wstrb, bready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_write, rsp_cycles,
        input  arvalid, araddr, arprot, rready, awvalid, awaddr, awprot,
        input  wvalid, wdata, wstrb, bready
    );
endinterface

// File: rtl/caliptra_fpga_axil_initiator.sv
// Single-outstanding AXI4-Lite initiator: one command becomes one AXI read or write, and the
// response returns data, resp code and the accept-to-handshake latency.
module caliptra_fpga_axil_initiator #(
    parameter logic [2:0]  PROT  = 3'b000,
    parameter int unsigned LAT_W = 16
) (
    input logic aclk,
    input logic rstn,
    caliptra_fpga_axil_initiator_if.master bus
);
    typedef enum logic [2:0] {StIdle, StRdA, StRdD, StWrAw, StWrB, StRsp} state_e;

    state_e           state_q;
    logic             cmd_ready_q, rsp_valid_q, rsp_write_q;
    logic             arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic             aw_done_q, w_done_q, aw_done_d, w_done_d;
    logic [31:0]      araddr_q, awaddr_q;
    logic [63:0]      wdata_q, rsp_rdata_q;
    logic [7:0]       wstrb_q;
    logic [1:0]       rsp_resp_q;
    logic [LAT_W-1:0] cnt_q, cnt_d, rsp_cycles_q;

    always_comb begin
        cnt_d     = (cnt_q == {LAT_W{1'b1}}) ? cnt_q : cnt_q + LAT_W'(1);
        aw_done_d = aw_done_q | (awvalid_q & bus.awready);
        w_done_d  = w_done_q | (wvalid_q & bus.wready);
    end

    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_write_q  <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            araddr_q     <= '0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rsp_rdata_q  <= '0;
            rsp_resp_q   <= '0;
            cnt_q        <= '0;
            rsp_cycles_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_ready_q && bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        rsp_write_q <= bus.cmd_write;
                        if (bus.cmd_write) begin
                            awaddr_q  <= bus.cmd_addr;
                            wdata_q   <= bus.cmd_wdata;
                            wstrb_q   <= bus.cmd_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= StWrAw;
                        end else begin
                            araddr_q  <= bus.cmd_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= StRdA;
                        end
                    end
                end
                StRdA: begin
                    cnt_q <= cnt_d;
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdD;
                    end
                end
                StRdD: begin
                    cnt_q <= cnt_d;
                    if (bus.rvalid) begin
                        rsp_rdata_q  <= bus.rdata;
                        rsp_resp_q   <= bus.rresp;
                        rsp_cycles_q <= cnt_d;
                        rready_q     <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= StRsp;
                    end
                end
                StWrAw: begin
                    // AW and W retire independently; B waits for whichever finishes last.
                    cnt_q     <= cnt_d;
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (awvalid_q && bus.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && bus.wready) wvalid_q <= 1'b0;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= StWrB;
                    end
                end
                StWrB: begin
                    cnt_q <= cnt_d;
                    if (bus.bvalid) begin
                        rsp_resp_q   <= bus.bresp;
                        rsp_rdata_q  <= '0;
                        rsp_cycles_q <= cnt_d;
                        bready_q     <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= StRsp;
                    end
                end
                StRsp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_resp   = rsp_resp_q;
    assign bus.rsp_write  = rsp_write_q;
    assign bus.rsp_cycles = rsp_cycles_q;
    assign bus.arvalid    = arvalid_q;
    assign bus.araddr     = araddr_q;
    assign bus.arprot     = PROT;
    assign bus.rready     = rready_q;
    assign bus.awvalid    = awvalid_q;
    assign bus.awaddr     = awaddr_q;
    assign bus.awprot     = PROT;
    assign bus.wvalid     = wvalid_q;
    assign bus.wdata      = wdata_q;
    assign bus.wstrb      = wstrb_q;
    assign bus.bready     = bready_q;
endmodule
